// File: rtl/tile_map_write_arbiter.sv
// -----------------------------------------------------------------------------
// tile_map_write_arbiter
//
// Shares the single write port of tile_map_mem among NUM_REQ game-logic
// requesters. Each requester hands one tile write to a private pending slot
// through a valid/ready handshake. Pending slots are served round-robin, at
// most one registered memory write per clock, and only while wr_window is high.
//
// Ports:
//   clk        pixel clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester write request
//   req_ready  per-requester slot empty (combinational ~pending)
//   req_addr   per-requester map address, slice i = requester i
//   req_data   per-requester tile state, slice i = requester i
//   req_done   one-cycle pulse when slot i's write is issued
//   wr_window  grants allowed this cycle
//   we         memory write enable (registered)
//   wr_addr    memory write address (registered, holds when idle)
//   wr_data    memory write data (registered, holds when idle)
//   err_oob    one-cycle pulse: an accepted request addressed past the map
//   err_id     requester behind the most recent err_oob (holds)
// -----------------------------------------------------------------------------
module tile_map_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_ROW    = 11,
  parameter int NUM_COL    = 19,
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = $clog2(NUM_ROW*NUM_COL),
  localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_done,
  input  logic                             wr_window,
  output logic                             we,
  output logic [ADDR_WIDTH-1:0]            wr_addr,
  output logic [DATA_WIDTH-1:0]            wr_data,
  output logic                             err_oob,
  output logic [ID_WIDTH-1:0]              err_id
);

  localparam int DEPTH = NUM_ROW*NUM_COL;

  logic [NUM_REQ-1:0]    pending_r;
  logic [ADDR_WIDTH-1:0] slot_addr_r [NUM_REQ];
  logic [DATA_WIDTH-1:0] slot_data_r [NUM_REQ];
  logic [ID_WIDTH-1:0]   rr_ptr_r;
  logic [NUM_REQ-1:0]    done_r;
  logic                  we_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic [DATA_WIDTH-1:0] wr_data_r;
  logic                  err_oob_r;
  logic [ID_WIDTH-1:0]   err_id_r;

  logic [NUM_REQ-1:0]    store_s;
  logic [NUM_REQ-1:0]    reject_s;
  logic [ID_WIDTH-1:0]   reject_idx_s;
  logic                  grant_s;
  logic [ID_WIDTH-1:0]   win_idx_s;
  logic [NUM_REQ-1:0]    clr_s;
  logic [ID_WIDTH-1:0]   next_ptr_s;
  int                    pos_s;

  assign req_ready = ~pending_r;
  assign req_done  = done_r;
  assign we        = we_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign err_oob   = err_oob_r;
  assign err_id    = err_id_r;

  // Classify handshakes: in-range accepts go to a slot, others are rejected.
  always_comb begin
    store_s      = '0;
    reject_s     = '0;
    reject_idx_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && !pending_r[i]) begin
        if (int'(req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]) < DEPTH) begin
          store_s[i] = 1'b1;
        end else begin
          reject_s[i] = 1'b1;
        end
      end else begin
        store_s[i]  = 1'b0;
        reject_s[i] = 1'b0;
      end
    end
    // Scan downwards so the lowest rejected index is the one that sticks.
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (reject_s[i]) begin
        reject_idx_s = ID_WIDTH'(i);
      end else begin
        reject_idx_s = reject_idx_s;
      end
    end
  end

  // Round-robin winner: smallest offset from rr_ptr whose slot is pending.
  always_comb begin
    grant_s    = wr_window && (|pending_r);
    win_idx_s  = '0;
    pos_s      = 0;
    clr_s      = '0;
    next_ptr_s = rr_ptr_r;
    for (int off = NUM_REQ-1; off >= 0; off--) begin
      pos_s = int'(rr_ptr_r) + off;
      if (pos_s >= NUM_REQ) begin
        pos_s = pos_s - NUM_REQ;
      end else begin
        pos_s = pos_s;
      end
      if (pending_r[pos_s]) begin
        win_idx_s = ID_WIDTH'(pos_s);
      end else begin
        win_idx_s = win_idx_s;
      end
    end
    if (grant_s) begin
      clr_s[win_idx_s] = 1'b1;
      if (win_idx_s == ID_WIDTH'(NUM_REQ-1)) begin
        next_ptr_s = '0;
      end else begin
        next_ptr_s = win_idx_s + ID_WIDTH'(1);
      end
    end else begin
      clr_s      = '0;
      next_ptr_s = rr_ptr_r;
    end
  end

  // Slot storage, pointer, registered memory port and error reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= '0;
      rr_ptr_r  <= '0;
      done_r    <= '0;
      we_r      <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
      err_oob_r <= 1'b0;
      err_id_r  <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_addr_r[i] <= '0;
        slot_data_r[i] <= '0;
      end
    end else begin
      // A slot is never granted and re-accepted on the same edge (ready=~pending).
      pending_r <= (pending_r & ~clr_s) | store_s;
      done_r    <= clr_s;
      we_r      <= grant_s;
      err_oob_r <= |reject_s;
      if (|reject_s) begin
        err_id_r <= reject_idx_s;
      end
      if (grant_s) begin
        wr_addr_r <= slot_addr_r[win_idx_s];
        wr_data_r <= slot_data_r[win_idx_s];
        rr_ptr_r  <= next_ptr_s;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (store_s[i]) begin
          slot_addr_r[i] <= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          slot_data_r[i] <= req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule
